// File: rtl/div_pkg.sv
// ============================================================================
// Module   : div_pkg
// Brief    : Shared state encoding and counter-width helper for the divider.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Wide enough to hold the iteration count N itself, not just N-1.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_trial_sub.sv
// ============================================================================
// Module   : div_trial_sub
// Brief    : (N+1)-bit ripple-carry trial subtractor, a - b as a + ~b + 1.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_trial_sub #(
    parameter int N = 32
) (
    input  logic [N:0]   i_a,
    input  logic [N:0]   i_b,
    output logic [N-1:0] o_diff,
    output logic         o_borrow
);

    logic [N:0] w_bn;
    logic [N:0] w_c;

    assign w_bn   = ~i_b;
    assign w_c[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign o_diff[i] = i_a[i] ^ w_bn[i] ^ w_c[i];
        assign w_c[i+1]  = (i_a[i] & w_bn[i]) | (i_a[i] & w_c[i]) | (w_bn[i] & w_c[i]);
    end

    // Only the carry of the top stage matters; its sum bit is the borrow mirror.
    assign o_borrow = ~((i_a[N] & w_bn[N]) | (i_a[N] & w_c[N]) | (w_bn[N] & w_c[N]));

endmodule

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module   : seq_restoring_divider
// Brief    : Multi-cycle unsigned restoring divider, one trial subtract/clock.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = cnt_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(N - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_rem;
    logic [N-1:0]     r_q;
    logic [N-1:0]     r_div;
    logic             r_dbz;

    logic [N-1:0]     w_diff;
    logic             w_borrow;
    logic             w_accept;

    div_trial_sub #(.N(N)) u_trial_sub (
        .i_a      ({r_rem, r_q[N-1]}),
        .i_b      ({1'b0, r_div}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    assign w_accept = start && (r_state != ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_div   <= '0;
            r_dbz   <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_div <= divisor;
            r_dbz <= (divisor == '0);
            // A zero divisor skips iteration and publishes its fixed result at once.
            if (divisor == '0) begin
                r_state <= ST_DONE;
                r_q     <= '1;
                r_rem   <= dividend;
            end else begin
                r_state <= ST_RUN;
                r_q     <= dividend;
                r_rem   <= '0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_q   <= {r_q[N-2:0], ~w_borrow};
                    r_rem <= w_borrow ? {r_rem[N-2:0], r_q[N-1]} : w_diff;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign quotient    = r_q;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// Module   : tb_seq_restoring_divider
// Brief    : Self-checking bench for seq_restoring_divider against a / and % model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int n_tests;
    int n_fail;

    seq_restoring_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and collect result; caller is positioned 1ns after a rising edge.
    task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b,
                          output int lat, output int bcnt,
                          output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
        start = 1'b1; dividend = a; divisor = b;
        tick();
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        lat = -1; bcnt = 0; q = 'x; r = 'x; z = 1'bx;
        for (int k = 0; k < 100; k++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = k; q = quotient; r = remainder; z = div_by_zero;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_tests++; if (quotient !== '0) begin n_fail++; $display("FAIL reset_quot got=%h exp=0", quotient); end
        n_tests++; if (remainder !== '0) begin n_fail++; $display("FAIL reset_rem got=%h exp=0", remainder); end
        n_tests++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [N-1:0] va [5] = '{32'd100, 32'd5, 32'hFFFF_FFFF, 32'h1234_5678, 32'd42};
        logic [N-1:0] vb [5] = '{32'd7,   32'd9, 32'd1,        32'h0000_1234, 32'd0};
        logic [N-1:0] eq, er, gq, gr;
        logic ez, gz;
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            model(va[i], vb[i], eq, er, ez);
            do_div(va[i], vb[i], lat, bc, gq, gr, gz);
            n_tests++; if (gq !== eq) begin n_fail++; $display("FAIL dir_quot[%0d] got=%h exp=%h", i, gq, eq); end
            n_tests++; if (gr !== er) begin n_fail++; $display("FAIL dir_rem[%0d] got=%h exp=%h", i, gr, er); end
            n_tests++; if (gz !== ez) begin n_fail++; $display("FAIL dir_dbz[%0d] got=%b exp=%b", i, gz, ez); end
            n_tests++; if (lat != ((vb[i] == 0) ? 0 : N)) begin n_fail++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, (vb[i] == 0) ? 0 : N); end
            n_tests++; if (bc != ((vb[i] == 0) ? 0 : N)) begin n_fail++; $display("FAIL dir_busy_cycles[%0d] got=%0d exp=%0d", i, bc, (vb[i] == 0) ? 0 : N); end
            tick();
            n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir_done_pulse[%0d] got=%b exp=0", i, done); end
            n_tests++; if (quotient !== eq || remainder !== er) begin n_fail++; $display("FAIL dir_hold[%0d] got=%h/%h exp=%h/%h", i, quotient, remainder, eq, er); end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] a, b, eq, er, gq, gr;
        logic ez, gz;
        int lat, bc;
        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 255);
                2:       b = a >> $urandom_range(0, 31);
                default: b = (i % 8 == 0) ? '0 : a;
            endcase
            model(a, b, eq, er, ez);
            do_div(a, b, lat, bc, gq, gr, gz);
            n_tests++;
            if (gq !== eq || gr !== er || gz !== ez || lat != ((b == 0) ? 0 : N)) begin
                n_fail++;
                $display("FAIL rand[%0d] %h/%h got=%h r %h z%b lat%0d exp=%h r %h z%b", i, a, b, gq, gr, gz, lat, eq, er, ez);
            end
            // Back-to-back: the next start lands in the DONE cycle on odd iterations.
            if (i % 2 == 0) tick();
        end
    endtask

    task automatic test_ignore_and_b2b();
        int k, lat, bc;
        logic [N-1:0] gq, gr;
        logic gz;
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        tick();
        start = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            if (k == 5) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            tick();
            k++;
        end
        start = 1'b0;
        n_tests++; if (k != N) begin n_fail++; $display("FAIL ign_latency got=%0d exp=%0d", k, N); end
        n_tests++; if (quotient !== 32'd14 || remainder !== 32'd2) begin n_fail++; $display("FAIL ign_result got=%0d r %0d exp=14 r 2", quotient, remainder); end
        do_div(32'd9, 32'd3, lat, bc, gq, gr, gz);
        n_tests++; if (gq !== 32'd3 || gr !== 32'd0) begin n_fail++; $display("FAIL b2b_result got=%0d r %0d exp=3 r 0", gq, gr); end
        n_tests++; if (lat != N) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, N); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bc, seen;
        logic [N-1:0] gq, gr;
        logic gz;
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got=busy%b done%b exp=0/0", busy, done); end
        n_tests++; if (quotient !== '0 || remainder !== '0) begin n_fail++; $display("FAIL midrst_out got=%h/%h exp=0/0", quotient, remainder); end
        repeat (2) tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d active cycles exp=0", seen); end
        do_div(32'd7, 32'd7, lat, bc, gq, gr, gz);
        n_tests++; if (gq !== 32'd1 || gr !== 32'd0 || lat != N) begin n_fail++; $display("FAIL midrst_after got=%0d r %0d lat%0d exp=1 r 0 lat%0d", gq, gr, lat, N); end
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_and_b2b();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
